// File: rtl/memory_pkg.sv
// memory_pkg: shared constants and types for the memory-access stage
package memory_pkg;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [31:0] NOP = 32'h00000013;
  typedef enum logic {IDLE, WAIT} state_e;
  localparam logic [1:0] FC_NONE = 2'd0;
  localparam logic [1:0] FC_MISALIGN = 2'd1;
  localparam logic [1:0] FC_ILLEGAL = 2'd2;
  localparam logic [1:0] FC_TIMEOUT = 2'd3;
  localparam logic [2:0] F3_LB = 3'd0;
  localparam logic [2:0] F3_LH = 3'd1;
  localparam logic [2:0] F3_LW = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB = 3'd0;
  localparam logic [2:0] F3_SH = 3'd1;
  localparam logic [2:0] F3_SW = 3'd2;
endpackage

// File: rtl/load_align.sv
// load_align: extracts the addressed lane of read data and sign/zero-extends it
module load_align
  import memory_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  output logic [31:0] rd
);
  logic [7:0] b;
  logic [15:0] h;
  always_comb begin
    b = rdata[{lane, 3'b000} +: 8];
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    rd = funct3 == F3_LB  ? {{24{b[7]}}, b} :
         funct3 == F3_LBU ? {24'b0, b} :
         funct3 == F3_LH  ? {{16{h[15]}}, h} :
         funct3 == F3_LHU ? {16'b0, h} : rdata;
  end
endmodule

// File: rtl/memory_access.sv
// memory_access: pipeline memory stage performing loads/stores over a req/ack bus
module memory_access
  import memory_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] IR_in,
  input  logic [31:0] A_in,
  input  logic [31:0] B_in,
  input  logic [31:0] PC_in,
  output logic [31:0] IR,
  output logic [31:0] RD,
  output logic [31:0] A,
  output logic [31:0] PC,
  output logic        out_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        fault,
  output logic [1:0]  fault_code
);
  localparam int CW = $clog2(TIMEOUT);
  state_e state_q, state_d;
  logic [31:0] ir_q, ir_d, rd_q, rd_d, a_q, a_d, pc_q, pc_d;
  logic [31:0] ir_l_q, ir_l_d, a_l_q, a_l_d, pc_l_q, pc_l_d, wdata_q, wdata_d;
  logic valid_q, valid_d, req_q, req_d, we_q, we_d, fault_q, fault_d;
  logic [3:0] be_q, be_d;
  logic [1:0] code_q, code_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] f3;
  logic is_ld, is_st, illegal, misaligned;
  logic [3:0] st_be;
  logic [31:0] st_wdata, ld_rd;
  assign f3 = IR_in[14:12];
  assign is_ld = IR_in[6:0] == OP_LOAD;
  assign is_st = IR_in[6:0] == OP_STORE;
  assign illegal = is_ld ? (f3 == 3'd3 || f3[2:1] == 2'b11) : is_st && (f3 == 3'd3 || f3[2]);
  assign misaligned = (f3[1:0] == 2'b01 && A_in[0]) || (f3[1:0] == 2'b10 && A_in[1:0] != 2'b00);
  assign st_be = f3[1:0] == 2'b00 ? 4'b0001 << A_in[1:0] :
                 f3[1:0] == 2'b01 ? 4'b0011 << {A_in[1], 1'b0} : 4'hF;
  assign st_wdata = f3[1:0] == 2'b00 ? {4{B_in[7:0]}} :
                    f3[1:0] == 2'b01 ? {2{B_in[15:0]}} : B_in;
  load_align u_align (
    .rdata (mem_rdata),
    .funct3(ir_l_q[14:12]),
    .lane  (a_l_q[1:0]),
    .rd    (ld_rd)
  );
  always_comb begin
    state_d = state_q;
    ir_d = NOP;
    rd_d = '0;
    a_d = '0;
    pc_d = '0;
    valid_d = 1'b0;
    fault_d = 1'b0;
    code_d = code_q;
    req_d = req_q;
    we_d = we_q;
    be_d = be_q;
    wdata_d = wdata_q;
    cnt_d = cnt_q;
    ir_l_d = ir_l_q;
    a_l_d = a_l_q;
    pc_l_d = pc_l_q;
    if (state_q == IDLE) begin
      if (in_valid && !is_ld && !is_st) begin
        ir_d = IR_in;
        a_d = A_in;
        pc_d = PC_in;
        valid_d = 1'b1;
      end else if (in_valid && (illegal || misaligned)) begin
        fault_d = 1'b1;
        code_d = illegal ? FC_ILLEGAL : FC_MISALIGN;
      end else if (in_valid) begin
        ir_l_d = IR_in;
        a_l_d = A_in;
        pc_l_d = PC_in;
        req_d = 1'b1;
        we_d = is_st;
        be_d = is_st ? st_be : 4'hF;
        wdata_d = st_wdata;
        cnt_d = '0;
        state_d = WAIT;
      end
    end else if (mem_ack) begin
      ir_d = ir_l_q;
      rd_d = we_q ? '0 : ld_rd;
      a_d = a_l_q;
      pc_d = pc_l_q;
      valid_d = 1'b1;
      req_d = 1'b0;
      be_d = '0;
      state_d = IDLE;
    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
      req_d = 1'b0;
      be_d = '0;
      fault_d = 1'b1;
      code_d = FC_TIMEOUT;
      state_d = IDLE;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ir_q <= NOP;
      rd_q <= '0;
      a_q <= '0;
      pc_q <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      code_q <= FC_NONE;
      req_q <= 1'b0;
      we_q <= 1'b0;
      be_q <= '0;
      wdata_q <= '0;
      cnt_q <= '0;
      ir_l_q <= NOP;
      a_l_q <= '0;
      pc_l_q <= '0;
    end else begin
      state_q <= state_d;
      ir_q <= ir_d;
      rd_q <= rd_d;
      a_q <= a_d;
      pc_q <= pc_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      code_q <= code_d;
      req_q <= req_d;
      we_q <= we_d;
      be_q <= be_d;
      wdata_q <= wdata_d;
      cnt_q <= cnt_d;
      ir_l_q <= ir_l_d;
      a_l_q <= a_l_d;
      pc_l_q <= pc_l_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign IR = ir_q;
  assign RD = rd_q;
  assign A = a_q;
  assign PC = pc_q;
  assign out_valid = valid_q;
  assign mem_req = req_q;
  assign mem_we = we_q;
  assign mem_addr = a_l_q[31:2];
  assign mem_be = be_q;
  assign mem_wdata = wdata_q;
  assign fault = fault_q;
  assign fault_code = code_q;
endmodule
